// File: rtl/control_batalla.sv
// Battleship game controller: placement and shooting phases on two 5x5 boards
// held outside this block, accessed via a combinational read port and a one-cell write port.
module control_batalla #(
  parameter int N_BARCOS = 3,
  parameter int T_TURNO  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       jug_valid,
  input  logic [2:0] jug_fila,
  input  logic [2:0] jug_col,
  input  logic       pc_valid,
  input  logic [2:0] pc_fila,
  input  logic [2:0] pc_col,
  output logic       rd_tab,
  output logic [2:0] rd_fila,
  output logic [2:0] rd_col,
  input  logic [1:0] rd_dato,
  output logic       wr_en,
  output logic       wr_tab,
  output logic [2:0] wr_fila,
  output logic [2:0] wr_col,
  output logic [1:0] wr_dato,
  output logic       limpiar,
  output logic       ack,
  output logic       err,
  output logic       turno,
  output logic [2:0] estado,
  output logic [3:0] aciertos_jug,
  output logic [3:0] aciertos_pc,
  output logic       gano_jug,
  output logic       gano_pc
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, COL_JUG = 3'd1, COL_PC = 3'd2, TURNO_JUG = 3'd3,
    TURNO_PC = 3'd4, EVAL = 3'd5, APLICAR = 3'd6, FIN = 3'd7
  } estado_t;

  localparam logic [1:0] AGUA          = 2'b00;
  localparam logic [1:0] BARCO         = 2'b01;
  localparam logic [1:0] TIRO_FALLADO  = 2'b10;
  localparam logic [1:0] TIRO_ACERTADO = 2'b11;
  localparam logic [3:0] N_OBJ         = 4'(N_BARCOS);
  localparam logic [7:0] T_LIM         = 8'(T_TURNO - 1);

  estado_t    state_q, state_d;
  logic [2:0] fila_q, fila_d, col_q, col_d;
  logic       src_q, src_d, disp_q, disp_d;
  logic [3:0] colocados_q, colocados_d;
  logic [3:0] aciertos_jug_q, aciertos_jug_d, aciertos_pc_q, aciertos_pc_d;
  logic       gano_jug_q, gano_jug_d, gano_pc_q, gano_pc_d;
  logic       turno_q, turno_d;
  logic [7:0] timer_q, timer_d;
  logic       wr_en_q, wr_en_d, wr_tab_q, wr_tab_d;
  logic [2:0] wr_fila_q, wr_fila_d, wr_col_q, wr_col_d;
  logic [1:0] wr_dato_q, wr_dato_d;
  logic       ack_q, ack_d, err_q, err_d;
  logic       limpiar_c;

  logic       req_v, req_src, en_turno, en_rango, tgt;
  logic [2:0] req_f, req_c;
  logic [3:0] cnt_disp, cnt_nuevo;

  // Placements target the requester's own board, shots the opponent's.
  assign tgt = disp_q ? ~src_q : src_q;

  always_comb begin
    state_d        = state_q;
    fila_d         = fila_q;
    col_d          = col_q;
    src_d          = src_q;
    disp_d         = disp_q;
    colocados_d    = colocados_q;
    aciertos_jug_d = aciertos_jug_q;
    aciertos_pc_d  = aciertos_pc_q;
    gano_jug_d     = gano_jug_q;
    gano_pc_d      = gano_pc_q;
    wr_en_d        = 1'b0;
    wr_tab_d       = 1'b0;
    wr_fila_d      = 3'd0;
    wr_col_d       = 3'd0;
    wr_dato_d      = AGUA;
    ack_d          = 1'b0;
    err_d          = 1'b0;
    limpiar_c      = 1'b0;
    req_v          = 1'b0;
    req_src        = 1'b0;
    req_f          = 3'd0;
    req_c          = 3'd0;
    cnt_disp       = 4'd0;
    cnt_nuevo      = 4'd0;

    case (state_q)
      COL_JUG, TURNO_JUG: begin
        req_v = jug_valid;
        req_f = jug_fila;
        req_c = jug_col;
      end
      COL_PC, TURNO_PC: begin
        req_v   = pc_valid;
        req_f   = pc_fila;
        req_c   = pc_col;
        req_src = 1'b1;
      end
      default: ;
    endcase
    en_turno = (state_q == TURNO_JUG) || (state_q == TURNO_PC);
    en_rango = (req_f <= 3'd4) && (req_c <= 3'd4);

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          limpiar_c      = 1'b1;
          colocados_d    = 4'd0;
          aciertos_jug_d = 4'd0;
          aciertos_pc_d  = 4'd0;
          gano_jug_d     = 1'b0;
          gano_pc_d      = 1'b0;
          state_d        = COL_JUG;
        end
      end
      COL_JUG, COL_PC, TURNO_JUG, TURNO_PC: begin
        // A request in the timeout cycle takes priority over passing the turn.
        if (req_v) begin
          if (!en_rango) begin
            err_d = 1'b1;
          end else begin
            fila_d  = req_f;
            col_d   = req_c;
            src_d   = req_src;
            disp_d  = en_turno;
            state_d = EVAL;
          end
        end else if (en_turno && timer_q >= T_LIM) begin
          err_d   = 1'b1;
          state_d = (state_q == TURNO_JUG) ? TURNO_PC : TURNO_JUG;
        end
      end
      EVAL: begin
        state_d = APLICAR;
        if (rd_dato == AGUA || (disp_q && rd_dato == BARCO)) begin
          wr_en_d   = 1'b1;
          ack_d     = 1'b1;
          wr_tab_d  = tgt;
          wr_fila_d = fila_q;
          wr_col_d  = col_q;
          if (!disp_q)               wr_dato_d = BARCO;
          else if (rd_dato == AGUA)  wr_dato_d = TIRO_FALLADO;
          else                       wr_dato_d = TIRO_ACERTADO;
        end else begin
          err_d = 1'b1;
        end
      end
      APLICAR: begin
        if (!disp_q) begin
          state_d = src_q ? COL_PC : COL_JUG;
          if (wr_en_q) begin
            if (colocados_q + 4'd1 == N_OBJ) begin
              colocados_d = 4'd0;
              state_d     = src_q ? TURNO_JUG : COL_PC;
            end else begin
              colocados_d = colocados_q + 4'd1;
            end
          end
        end else begin
          state_d   = src_q ? TURNO_PC : TURNO_JUG;
          cnt_disp  = src_q ? aciertos_pc_q : aciertos_jug_q;
          cnt_nuevo = cnt_disp;
          if (wr_en_q) begin
            if (wr_dato_q == TIRO_ACERTADO && cnt_disp != 4'hF) cnt_nuevo = cnt_disp + 4'd1;
            if (src_q) aciertos_pc_d  = cnt_nuevo;
            else       aciertos_jug_d = cnt_nuevo;
            if (cnt_nuevo == N_OBJ) begin
              state_d = FIN;
              if (src_q) gano_pc_d  = 1'b1;
              else       gano_jug_d = 1'b1;
            end else begin
              state_d = src_q ? TURNO_JUG : TURNO_PC;
            end
          end
        end
      end
      default: ;
    endcase

    case (state_d)
      TURNO_JUG:     turno_d = 1'b0;
      TURNO_PC:      turno_d = 1'b1;
      EVAL, APLICAR: turno_d = turno_q;
      default:       turno_d = 1'b0;
    endcase

    // Timer restarts on every entry into a turn state, including retries.
    timer_d = 8'd0;
    if ((state_d == TURNO_JUG || state_d == TURNO_PC) && state_d == state_q)
      timer_d = timer_q + 8'(timer_q != 8'hFF);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      fila_q         <= 3'd0;
      col_q          <= 3'd0;
      src_q          <= 1'b0;
      disp_q         <= 1'b0;
      colocados_q    <= 4'd0;
      aciertos_jug_q <= 4'd0;
      aciertos_pc_q  <= 4'd0;
      gano_jug_q     <= 1'b0;
      gano_pc_q      <= 1'b0;
      turno_q        <= 1'b0;
      timer_q        <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_tab_q       <= 1'b0;
      wr_fila_q      <= 3'd0;
      wr_col_q       <= 3'd0;
      wr_dato_q      <= 2'b00;
      ack_q          <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      fila_q         <= fila_d;
      col_q          <= col_d;
      src_q          <= src_d;
      disp_q         <= disp_d;
      colocados_q    <= colocados_d;
      aciertos_jug_q <= aciertos_jug_d;
      aciertos_pc_q  <= aciertos_pc_d;
      gano_jug_q     <= gano_jug_d;
      gano_pc_q      <= gano_pc_d;
      turno_q        <= turno_d;
      timer_q        <= timer_d;
      wr_en_q        <= wr_en_d;
      wr_tab_q       <= wr_tab_d;
      wr_fila_q      <= wr_fila_d;
      wr_col_q       <= wr_col_d;
      wr_dato_q      <= wr_dato_d;
      ack_q          <= ack_d;
      err_q          <= err_d;
    end
  end

  assign rd_tab       = (state_q == EVAL) && tgt;
  assign rd_fila      = (state_q == EVAL) ? fila_q : 3'd0;
  assign rd_col       = (state_q == EVAL) ? col_q : 3'd0;
  assign wr_en        = wr_en_q;
  assign wr_tab       = wr_tab_q;
  assign wr_fila      = wr_fila_q;
  assign wr_col       = wr_col_q;
  assign wr_dato      = wr_dato_q;
  assign limpiar      = limpiar_c && rst;
  assign ack          = ack_q;
  assign err          = err_q;
  assign turno        = turno_q;
  assign estado       = state_q;
  assign aciertos_jug = aciertos_jug_q;
  assign aciertos_pc  = aciertos_pc_q;
  assign gano_jug     = gano_jug_q;
  assign gano_pc      = gano_pc_q;
endmodule
